// File: rtl/sd_pkg.sv
// Shared types and constants for the SD sector cache: FSM state encoding, sector size, clog2 helper.
package sd_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOOKUP,
        FILL,
        RESPOND
    } state_t;

    localparam int SECTOR_BYTES = 512;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sd_sektor_cache_if.sv
// CPU-side read bus of the SD sector cache: request, response pulses and hit/miss statistics.
interface sd_sektor_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_BYTES = 4
);
    logic [ADDR_WIDTH-1:0]   Adresse;
    logic                    Lesen;
    logic                    Invalidieren;
    logic [8*WORD_BYTES-1:0] Daten;
    logic                    Fertig;
    logic                    Fehler;
    logic                    Busy;
    logic [15:0]             Treffer;
    logic [15:0]             Fehlzugriffe;

    modport master (
        output Adresse, Lesen, Invalidieren,
        input  Daten, Fertig, Fehler, Busy, Treffer, Fehlzugriffe
    );

    modport slave (
        input  Adresse, Lesen, Invalidieren,
        output Daten, Fertig, Fehler, Busy, Treffer, Fehlzugriffe
    );
endinterface

// File: rtl/sd_sektor_puffer.sv
// Sector buffer: simple dual-port synchronous RAM, one write port, read data one cycle after the address.
module sd_sektor_puffer
    import sd_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int WIDTH = 32,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; the valid flag guards stale contents.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sd_sektor_cache.sv
// One-sector read cache in front of the SPI SD controller; a miss streams 512 card bytes into the buffer.
// Optional hit/miss counters are built when SD_CACHE_STATS_EN is defined.
module sd_sektor_cache
    import sd_pkg::*;
#(
    parameter int WORD_BYTES    = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int SD_BLOCK_ADDR = 0,
    parameter int TIMEOUT       = 2**20
) (
    input  logic        Clock,
    input  logic        Reset,
    sd_sektor_cache_if.slave bus,
    output logic        sd_rd,
    output logic [31:0] sd_adresse,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    input  logic        sd_ready
);

    localparam int WPS      = SECTOR_BYTES / WORD_BYTES;
    localparam int WORD_W   = 8 * WORD_BYTES;
    localparam int WIDX_W   = clog2(WPS);
    localparam int SEKTOR_W = ADDR_WIDTH - WIDX_W;
    localparam int TMO_W    = clog2(TIMEOUT);

    state_t              state;
    logic [SEKTOR_W-1:0] req_sektor;
    logic [SEKTOR_W-1:0] tag;
    logic [WIDX_W-1:0]   req_wort;
    logic                valid;
    logic                from_fill;
    logic [8:0]          byte_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [WORD_W-1:0]   asm_word;
    logic [WORD_W-1:0]   fill_word;
    logic [WORD_W-1:0]   rd_data;

    logic [WORD_W-1:0]   asm_next;
    logic                word_done;
    logic                wr_en;
    logic [WIDX_W-1:0]   wr_addr;
    logic                hit;
    logic [31:0]         sektor_32;

    // NOTE: every always_comb output gets an unconditional assignment so no latch is inferred.
    always_comb begin
        asm_next  = (asm_word << 8) | WORD_W'(sd_dout);
        word_done = (32'(byte_cnt) % WORD_BYTES) == WORD_BYTES - 1;
        wr_addr   = WIDX_W'(32'(byte_cnt) / WORD_BYTES);
        wr_en     = (state == FILL) && sd_byte_available && word_done;
        hit       = valid && (tag == req_sektor);
        sektor_32 = 32'(req_sektor);
    end

    sd_sektor_puffer #(
        .DEPTH (WPS),
        .WIDTH (WORD_W)
    ) u_puffer (
        .clk     (Clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (asm_next),
        .rd_addr (req_wort),
        .rd_data (rd_data)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= INIT;
            bus.Daten  <= '0;
            bus.Fertig <= 1'b0;
            bus.Fehler <= 1'b0;
            bus.Busy   <= 1'b1;
            sd_rd      <= 1'b0;
            sd_adresse <= '0;
            valid      <= 1'b0;
            tag        <= '0;
            req_sektor <= '0;
            req_wort   <= '0;
            from_fill  <= 1'b0;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            asm_word   <= '0;
            fill_word  <= '0;
        end else begin
            bus.Fertig <= 1'b0;
            bus.Fehler <= 1'b0;
            case (state)
                INIT: begin
                    bus.Busy <= 1'b1;
                    if (sd_ready) state <= IDLE;
                end
                // Busy drops one cycle after entering IDLE, so the first IDLE cycle ignores requests.
                IDLE: begin
                    if (!bus.Busy && bus.Lesen) begin
                        req_sektor <= bus.Adresse[ADDR_WIDTH-1:WIDX_W];
                        req_wort   <= bus.Adresse[WIDX_W-1:0];
                        bus.Busy   <= 1'b1;
                        state      <= LOOKUP;
                    end else begin
                        bus.Busy <= 1'b0;
                        if (!bus.Busy && bus.Invalidieren) valid <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        from_fill <= 1'b0;
                        state     <= RESPOND;
                    end else if (sd_ready) begin
                        valid      <= 1'b0;
                        from_fill  <= 1'b1;
                        sd_adresse <= (SD_BLOCK_ADDR != 0) ? sektor_32 : (sektor_32 << 9);
                        sd_rd      <= 1'b1;
                        byte_cnt   <= '0;
                        tmo_cnt    <= '0;
                        state      <= FILL;
                    end
                end
                // The requested word is captured on its way to the buffer, avoiding a read-during-write.
                FILL: begin
                    if (sd_byte_available) begin
                        sd_rd    <= 1'b0;
                        asm_word <= asm_next;
                        tmo_cnt  <= '0;
                        byte_cnt <= byte_cnt + 9'd1;
                        if (word_done && (wr_addr == req_wort)) fill_word <= asm_next;
                        if (byte_cnt == 9'd511) begin
                            tag   <= req_sektor;
                            valid <= 1'b1;
                            state <= RESPOND;
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        sd_rd      <= 1'b0;
                        valid      <= 1'b0;
                        bus.Fehler <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESPOND: begin
                    bus.Daten  <= from_fill ? fill_word : rd_data;
                    bus.Fertig <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef SD_CACHE_STATS_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus.Treffer      <= '0;
            bus.Fehlzugriffe <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (bus.Treffer != 16'hFFFF) bus.Treffer <= bus.Treffer + 16'd1;
            end else if (sd_ready) begin
                if (bus.Fehlzugriffe != 16'hFFFF) bus.Fehlzugriffe <= bus.Fehlzugriffe + 16'd1;
            end
        end
    end
`else
    assign bus.Treffer      = '0;
    assign bus.Fehlzugriffe = '0;
`endif

endmodule

// File: tb/tb_sd_sektor_cache.sv
// Self-checking bench for sd_sektor_cache: a sector-level cache model predicts hit/miss, data and pulse timing.
module tb_sd_sektor_cache;

    localparam int WB  = 4;
    localparam int AW  = 32;
    localparam int TMO = 64;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        sd_rd;
    logic [31:0] sd_adresse;
    logic [7:0]  sd_dout = 8'h00;
    logic        sd_byte_available = 1'b0;
    logic        sd_ready = 1'b0;

    sd_sektor_cache_if #(.ADDR_WIDTH(AW), .WORD_BYTES(WB)) bus ();

    sd_sektor_cache #(
        .WORD_BYTES    (WB),
        .ADDR_WIDTH    (AW),
        .SD_BLOCK_ADDR (0),
        .TIMEOUT       (TMO)
    ) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .bus               (bus),
        .sd_rd             (sd_rd),
        .sd_adresse        (sd_adresse),
        .sd_dout           (sd_dout),
        .sd_byte_available (sd_byte_available),
        .sd_ready          (sd_ready)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    bit          m_valid = 1'b0;
    logic [24:0] m_tag   = '0;
    int          m_hits  = 0;
    int          m_miss  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The card returns byte i of sector s as (i + (s-1)*13) mod 256; sector 1 is plain i mod 256.
    function automatic logic [7:0] card_byte(input logic [24:0] s, input int i);
        return 8'(i + (int'(s) - 1) * 13);
    endfunction

    function automatic logic [31:0] model_word(input logic [24:0] s, input int w);
        return {card_byte(s, 4*w), card_byte(s, 4*w+1), card_byte(s, 4*w+2), card_byte(s, 4*w+3)};
    endfunction

    // Single compare process: every response pulse must match the next predicted outcome.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset) begin
            check("pulse_exclusive", 32'(bus.Fertig & bus.Fehler), 32'd0);
            if (bus.Fertig || bus.Fehler) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'(bus.Fehler), 32'(e.is_err));
                    if (bus.Fertig && !e.is_err) check("read_data", bus.Daten, e.data);
                end
            end
        end
    end

    task automatic check_stats();
`ifdef SD_CACHE_STATS_EN
        check("treffer", 32'(bus.Treffer), 32'(m_hits));
        check("fehlzugriffe", 32'(bus.Fehlzugriffe), 32'(m_miss));
`else
        check("treffer_tied", 32'(bus.Treffer), 32'd0);
        check("fehlzugriffe_tied", 32'(bus.Fehlzugriffe), 32'd0);
`endif
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.Busy && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (bus.Busy) check("wait_idle_timeout", 32'(bus.Busy), 32'd0);
    endtask

    task automatic do_inval();
        wait_idle();
        bus.Invalidieren = 1'b1;
        @(negedge Clock);
        bus.Invalidieren = 1'b0;
        m_valid = 1'b0;
    endtask

    // stop_at < 512 ends the byte stream early; with do_reset the fill is then aborted by Reset.
    task automatic do_read(input logic [31:0] addr, input int stop_at, input bit with_inval,
                           input bit do_reset, output logic [31:0] got_data, output logic [31:0] got_adr);
        logic [24:0] s;
        int          w;
        bit          hit;
        int          n;
        int          gap;
        exp_t        e;
        s        = addr[31:7];
        w        = int'(addr[6:0]);
        got_data = '0;
        got_adr  = '0;
        wait_idle();
        hit = m_valid && (m_tag == s);
        if (hit || (stop_at >= 512 && !do_reset)) begin
            e.is_err = 1'b0;
            e.data   = model_word(s, w);
            exp_q.push_back(e);
        end else if (!do_reset) begin
            e.is_err = 1'b1;
            e.data   = '0;
            exp_q.push_back(e);
        end
        bus.Adresse      = addr;
        bus.Lesen        = 1'b1;
        bus.Invalidieren = with_inval;
        @(negedge Clock);
        bus.Lesen        = 1'b0;
        bus.Invalidieren = 1'b0;
        check("busy_after_accept", 32'(bus.Busy), 32'd1);
        if (hit) begin
            m_hits++;
            check("hit_fertig_n", 32'(bus.Fertig), 32'd0);
            @(negedge Clock);
            check("hit_fertig_n1", 32'(bus.Fertig), 32'd0);
            check("hit_no_sd_rd", 32'(sd_rd), 32'd0);
            @(negedge Clock);
            check("hit_fertig_n2", 32'(bus.Fertig), 32'd1);
            check("hit_busy_n2", 32'(bus.Busy), 32'd1);
            got_data = bus.Daten;
            @(negedge Clock);
            check("hit_busy_n3", 32'(bus.Busy), 32'd0);
            check("hit_no_sd_rd_n3", 32'(sd_rd), 32'd0);
        end else begin
            m_miss++;
            m_valid = 1'b0;
            n = 0;
            while (!sd_rd && n < 20) begin
                @(negedge Clock);
                n++;
            end
            check("miss_sd_rd", 32'(sd_rd), 32'd1);
            got_adr = sd_adresse;
            check("miss_sd_adresse", sd_adresse, 32'(s) << 9);
            for (int i = 0; i < stop_at; i++) begin
                gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
                repeat (gap) @(negedge Clock);
                if (i == 0) check("sd_rd_before_first", 32'(sd_rd), 32'd1);
                sd_dout           = card_byte(s, i);
                sd_byte_available = 1'b1;
                @(negedge Clock);
                sd_byte_available = 1'b0;
                if (i == 0) check("sd_rd_after_first", 32'(sd_rd), 32'd0);
            end
            if (do_reset) begin
                Reset = 1'b1;
                exp_q.delete();
                @(negedge Clock);
                check("reset_sd_rd", 32'(sd_rd), 32'd0);
                check("reset_busy", 32'(bus.Busy), 32'd1);
                check("reset_fertig", 32'(bus.Fertig), 32'd0);
                m_valid = 1'b0;
                m_hits  = 0;
                m_miss  = 0;
                @(negedge Clock);
                Reset = 1'b0;
            end else if (stop_at >= 512) begin
                check("miss_fertig_early", 32'(bus.Fertig), 32'd0);
                @(negedge Clock);
                check("miss_fertig_latency", 32'(bus.Fertig), 32'd1);
                got_data = bus.Daten;
                m_valid  = 1'b1;
                m_tag    = s;
            end else begin
                n = 0;
                while (!bus.Fehler && n < TMO + 10) begin
                    @(negedge Clock);
                    n++;
                end
                check("timeout_fehler", 32'(bus.Fehler), 32'd1);
                check("timeout_no_fertig", 32'(bus.Fertig), 32'd0);
                check("timeout_sd_rd", 32'(sd_rd), 32'd0);
                @(negedge Clock);
                check("busy_after_fehler", 32'(bus.Busy), 32'd0);
            end
        end
        check_stats();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] addr;
        logic [24:0] sek;
        int          r;
        logic [24:0] sectors [5];
        sectors = '{25'd0, 25'd1, 25'd2, 25'd3, 25'h1FFFFFF};

        bus.Adresse      = '0;
        bus.Lesen        = 1'b0;
        bus.Invalidieren = 1'b0;

        // Reset values and INIT -> IDLE handshake.
        repeat (3) @(negedge Clock);
        check("rst_daten", bus.Daten, 32'd0);
        check("rst_fertig", 32'(bus.Fertig), 32'd0);
        check("rst_fehler", 32'(bus.Fehler), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd1);
        check("rst_sd_rd", 32'(sd_rd), 32'd0);
        check("rst_sd_adresse", sd_adresse, 32'd0);
        Reset = 1'b0;
        repeat (5) begin
            @(negedge Clock);
            check("init_busy", 32'(bus.Busy), 32'd1);
        end
        sd_ready = 1'b1;
        @(negedge Clock);
        check("busy_ready_edge", 32'(bus.Busy), 32'd1);
        @(negedge Clock);
        check("busy_falls", 32'(bus.Busy), 32'd0);
        check("idle_daten", bus.Daten, 32'd0);
        check("idle_fertig", 32'(bus.Fertig), 32'd0);

        // Cold read, then hit in the same sector.
        do_read(32'h85, 512, 1'b0, 1'b0, d, a);
        check("cold_data_literal", d, 32'h14151617);
        check("cold_adr_literal", a, 32'h200);
        do_read(32'h80, 512, 1'b0, 1'b0, d, a);
        check("hit_data_literal", d, 32'h00010203);
`ifdef SD_CACHE_STATS_EN
        check("treffer_literal", 32'(bus.Treffer), 32'd1);
        check("fehlzugriffe_literal", 32'(bus.Fehlzugriffe), 32'd1);
`endif

        // Invalidate forces a refill; Lesen beats a simultaneous Invalidieren.
        do_inval();
        do_read(32'h80, 512, 1'b0, 1'b0, d, a);
        check("refill_adr_literal", a, 32'h200);
        do_read(32'h84, 512, 1'b1, 1'b0, d, a);
        do_read(32'hFF, 512, 1'b0, 1'b0, d, a);
        check("last_word_literal", d, 32'hFCFDFEFF);

        // Fill timeout, then the same sector misses again.
        do_read(32'h103, 100, 1'b0, 1'b0, d, a);
        do_read(32'h103, 512, 1'b0, 1'b0, d, a);
        check("after_timeout_adr_literal", a, 32'h400);

        // Reset in the middle of a fill; after re-init the same address misses.
        do_read(32'h180, 300, 1'b0, 1'b1, d, a);
        do_read(32'h180, 512, 1'b0, 1'b0, d, a);
        check("after_reset_adr_literal", a, 32'h600);

        // Randomized mix of hits, misses and invalidations.
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                do_inval();
            end else begin
                sek  = sectors[$urandom_range(0, 4)];
                addr = {sek, 7'($urandom_range(0, 127))};
                do_read(addr, 512, (r == 1), 1'b0, d, a);
            end
        end

        repeat (5) @(negedge Clock);
        check("no_pending_responses", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
